// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the synchronous RAM controller.
package sync_ram_pkg;

  // Width of one byte lane addressed by a byte-enable bit.
  localparam int BYTE_W = 8;

  // Controller states: INIT sweeps the array, IDLE serves requests.
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM with byte-enable write and registered read.
// The read register only updates on a read strobe, so it holds between reads.
module ram_array
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic                         re_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  localparam int NB    = DATA_WIDTH / BYTE_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane masked write and registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_ram_ctrl.sv
// Controller for a byte-writable synchronous RAM: power-up/clear init sweep,
// request acceptance, and a fixed-latency (1 or 2) read response pipeline.
module sync_ram_ctrl
  import sync_ram_pkg::*;
#(
  parameter int                   ADDR_WIDTH   = 4,
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy
);

  localparam int                    NB        = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic                    accept;
  logic                    rd_accept;
  logic                    ram_we;
  logic                    ram_re;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [NB-1:0]           ram_be;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    vld_p1_q;

  // Ready and busy depend only on the registered state.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == INIT);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_write;

  // State register and sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: sweep every address once, then serve requests until a clear.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = INIT;
          sweep_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // RAM port mux: the sweep owns the port in INIT, accepted requests in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr;
    ram_wdata = wdata;
    ram_be    = byte_en;
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_addr  = sweep_q;
      ram_wdata = INIT_VALUE;
      ram_be    = '1;
    end else if (accept) begin
      ram_we = req_write;
      ram_re = ~req_write;
    end
  end

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .be_i    (ram_be),
    .rdata_o (ram_rdata)
  );

  // First response stage: valid travels with the RAM's registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= rd_accept;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld_p2_q;
    logic [DATA_WIDTH-1:0] rdata_p2_q;

    // Second response stage: capture data only on a valid beat so it holds.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p2_q   <= 1'b0;
        rdata_p2_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          rdata_p2_q <= ram_rdata;
        end
      end
    end

    assign rsp_valid = vld_p2_q;
    assign rdata     = rdata_p2_q;
  end else begin : g_lat1
    logic seen_q;

    // The RAM read register has no reset; mask it to zero until its first read.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        seen_q <= 1'b0;
      end else if (rd_accept) begin
        seen_q <= 1'b1;
      end
    end

    assign rsp_valid = vld_p1_q;
    assign rdata     = seen_q ? ram_rdata : '0;
  end

endmodule

// File: doc/sync_ram_ctrl.md
SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address bits; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32: word width; SHALL be a multiple of 8.
REQ-003 Parameter READ_LATENCY, default 1: accept-to-response cycles; legal values 1 or 2.
REQ-004 Parameter INIT_VALUE, default all-ones: value written to every word by the init sweep.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  one-cycle pulse requesting a re-initialisation sweep.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  controller can accept a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 addr  input  ADDR_WIDTH  word address.
REQ-012 wdata  input  DATA_WIDTH  write data.
REQ-013 byte_en  input  DATA_WIDTH/8  per-byte write enable; ignored on reads.
REQ-014 rsp_valid  output  1  one-cycle pulse marking valid rdata.
REQ-015 rdata  output  DATA_WIDTH  read data; holds its last value when rsp_valid is low.
REQ-016 busy  output  1  init sweep in progress.

Function
REQ-017 FSM states: INIT and IDLE; INIT is the reset state.
REQ-018 INIT: write INIT_VALUE to address sweep_cnt each cycle, counting 0 to 2**ADDR_WIDTH-1, with all bytes enabled.
REQ-019 INIT -> IDLE on the cycle after the write to the last address; the sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-020 busy = 1 and req_ready = 0 throughout INIT.
REQ-021 IDLE: req_ready = 1; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-022 Accepted write: update only the bytes whose byte_en bit is 1 at the clock edge of acceptance; other bytes are unchanged.
REQ-023 A write with byte_en = 0 is accepted and leaves memory unchanged.
REQ-024 Accepted read: rsp_valid = 1 exactly READ_LATENCY cycles after acceptance, with rdata = the word at addr as of the acceptance edge.
REQ-025 Reads are fully pipelined: back-to-back reads produce back-to-back rsp_valid pulses in order.
REQ-026 A read accepted on the cycle after a write to the same address returns the new data.
REQ-027 There is no response backpressure; every accepted read produces exactly one response.
REQ-028 clear in IDLE: on the next cycle go to INIT, restarting at sweep_cnt = 0; a request presented in the same cycle as clear is still accepted.
REQ-029 clear in INIT is ignored; the sweep is not restarted.
REQ-030 Reads accepted before a clear still deliver their responses during INIT, with data as of their acceptance edge.
REQ-031 Outputs are registered; there is no combinational path from req_valid to any output except req_ready, which depends only on state.

Reset
REQ-032 While reset = 0: state = INIT, sweep_cnt = 0, rsp_valid = 0, rdata = 0, read pipeline cleared, busy = 1, req_ready = 0.
REQ-033 Memory contents are not reset directly; they are defined only after the sweep completes.
REQ-034 Reset asserted mid-sweep or mid-read: in-flight responses are discarded, and the sweep restarts from 0 after reset is released.

Structure
REQ-035 Shared package sync_ram_pkg SHALL hold the state enum (INIT, IDLE) and the byte-lane width constant (8).
REQ-036 Storage SHALL be one sub-module, ram_array: a single-port synchronous RAM with byte-enable write and registered read, no reset.
REQ-037 sync_ram_ctrl SHALL contain the FSM, sweep counter, request mux, and read-latency pipeline (an extra register stage when READ_LATENCY = 2).

Verification
REQ-038 Release reset, ADDR_WIDTH = 4 -> busy high for exactly 16 cycles; a read of each address returns INIT_VALUE.
REQ-039 Write 0x12345678 to addr 3 with byte_en = 4'b0101, then read addr 3 -> rdata = 0xFF34FF78 (after init to all-ones).
REQ-040 Reads of addr 0, 1, 2 on consecutive cycles with READ_LATENCY = 2 -> three consecutive rsp_valid pulses, starting 2 cycles after the first accept, in order.
REQ-041 Write 0xA5A5A5A5 to addr 5 then read addr 5 on the next cycle -> rdata = 0xA5A5A5A5.
REQ-042 Pulse clear with a read of addr 7 accepted in the same cycle -> addr-7 response is delivered, busy rises on the next cycle for 16 cycles, req_ready is 0 throughout.
REQ-043 Assert reset 5 cycles into a sweep -> no rsp_valid during reset; the sweep restarts at 0 after release and takes 16 cycles.
